i2c_init_seq: RTL and testbench
===============================

// Module: i2c_init_seq
// PURPOSE
//  Upstream sequencer for i2c_master: after reset (or on a RUN request) it walks an
//  external register table and issues one I2C write per entry (chip config, e.g.
//  HDMI TX / audio codec). Drives the master's START/ADDR/SUBADDR/WDATA and
//  consumes END/ACK. Retries NACKed writes and reports DONE or ERROR.
// PARAMETERS
//  DEV_ADDR    7'h39      7-bit I2C device address used for every write
//  NUM_REGS    8'd32      table entries, indices 0..NUM_REGS-1 (1..255)
//  PWRUP_CYC   24'd100000 CLK cycles to wait before the first entry
//  RETRY_MAX   3          extra attempts per NACKed entry (0..7)
//  GAP_CYC     16'd1000   CLK cycles idle between retry attempts
//  TIMEOUT_CYC 24'd500000 max cycles waiting on END before FAIL
//  AUTO_START  1          1: start automatically after reset; 0: wait for RUN
// PORTS
//  CLK          in   1   system clock, same domain as i2c_master
//  RESET_N      in   1   synchronous active-low reset
//  RUN          in   1   rising edge (re)starts the sequence from index 0
//  TBL_IDX      out  8   table index requested
//  TBL_DATA     in   16  {SUBADDR[15:8], WDATA[7:0]}, valid 1 cycle after TBL_IDX changes
//  I2C_START    out  1   start request to i2c_master (edge-triggered in master)
//  I2C_READ     out  1   tied 0 (writes only)
//  I2C_ADDR     out  7   = DEV_ADDR
//  I2C_SUBADDR  out  8   latched register address
//  I2C_WDATA    out  8   latched register data
//  I2C_END      in   1   master idle/done flag (1 at idle)
//  I2C_ACK      in   1   master ACK result, valid when END rises
//  BUSY         out  1   sequence in progress
//  DONE         out  1   all entries written with ACK; held until next run/reset
//  ERROR        out  1   an entry failed after all retries or END timed out; held
//  FAIL_IDX     out  8   index of failing entry (valid while ERROR=1)
// BEHAVIOUR
//  Reset (RESET_N=0 at a CLK edge): all outputs 0 (I2C_ADDR=DEV_ADDR), counters 0.
//   State -> PWRUP if AUTO_START else IDLE. Reset mid-transfer drops START at once;
//   sequencer then waits for I2C_END=1 (in PWRUP) before the first new START.
//  States:
//   IDLE  : BUSY=0. RUN rise (RUN=1, previous RUN=0) -> PWRUP; clears DONE/ERROR/retry count.
//   PWRUP : count PWRUP_CYC cycles AND I2C_END=1 -> FETCH, TBL_IDX=0.
//   FETCH : one wait cycle for table latency -> LOAD.
//   LOAD  : latch TBL_DATA into SUBADDR/WDATA -> SREQ.
//   SREQ  : I2C_START=1; hold until I2C_END=0 seen -> SWAIT (START=0 next cycle).
//           If END not low within TIMEOUT_CYC -> FAIL.
//   SWAIT : wait I2C_END=1. On rise sample I2C_ACK -> CHECK. Timeout -> FAIL.
//   CHECK : ACK=1 -> NEXT. ACK=0: retry count < RETRY_MAX -> GAP (count+1); else FAIL.
//   GAP   : idle GAP_CYC cycles -> SREQ (same latched data, no refetch).
//   NEXT  : retry count=0; TBL_IDX=NUM_REGS-1 -> DONEST; else TBL_IDX+1 -> FETCH.
//   DONEST: DONE=1, BUSY=0 -> IDLE.  FAIL: ERROR=1, FAIL_IDX=TBL_IDX, BUSY=0 -> IDLE.
//  BUSY=1 in every state except IDLE. START is never asserted with END=0 on entry to SREQ.
//  RUN rise while BUSY is ignored. RUN held high does not retrigger (edge only).
//  TBL_IDX never exceeds NUM_REGS-1; no wrap. Counters saturate and do not wrap.
//  Timeout counter restarts on each SREQ entry; shared by SREQ and SWAIT.
//  Min per-entry overhead: FETCH+LOAD+SREQ = 3 CLK before START plus master time.
// TESTING (bench: behavioural I2C slave + i2c_master, small PWRUP/GAP/TIMEOUT)
//  NUM_REGS=3, table {01:AA,02:BB,03:CC}, slave ACKs all -> 3 writes to 0x39 in order, DONE=1, ERROR=0.
//  Slave NACKs entry 1 twice then ACKs, RETRY_MAX=3 -> entry 1 sent 3 times, GAP_CYC apart, DONE=1.
//  Slave NACKs entry 2 always, RETRY_MAX=3 -> 4 attempts, ERROR=1, FAIL_IDX=2, DONE=0, entry 3 unsent.
//  END forced low (stuck master), TIMEOUT_CYC=1000 -> ERROR=1 about 1000 cycles after START.
//  AUTO_START=0: no activity until RUN rises; RUN pulse during BUSY ignored; second RUN after DONE reruns from idx 0.
//  RESET_N low during entry 1 transfer -> outputs 0 next edge; after release, no START until END=1 and PWRUP elapses.

Source files
------------

// File: rtl/i2c_init_seq.sv
// Register-table sequencer feeding an i2c_master: walks NUM_REGS table entries and
// issues one write per entry, retrying NACKed writes, then reports DONE or ERROR.
module i2c_init_seq #(
   parameter logic [6:0]  DEV_ADDR    = 7'h39,
   parameter logic [7:0]  NUM_REGS    = 8'd32,
   parameter logic [23:0] PWRUP_CYC   = 24'd100000,
   parameter int unsigned RETRY_MAX   = 3,
   parameter logic [15:0] GAP_CYC     = 16'd1000,
   parameter logic [23:0] TIMEOUT_CYC = 24'd500000,
   parameter bit          AUTO_START  = 1'b1
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        run_i,
   output logic [7:0]  tbl_idx_o,
   input  logic [15:0] tbl_data_i,
   output logic        i2c_start_o,
   output logic        i2c_read_o,
   output logic [6:0]  i2c_addr_o,
   output logic [7:0]  i2c_subaddr_o,
   output logic [7:0]  i2c_wdata_o,
   input  logic        i2c_end_i,
   input  logic        i2c_ack_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o,
   output logic [7:0]  fail_idx_o
);

   localparam logic [23:0] PWRUP_LAST   = (PWRUP_CYC == 24'd0) ? 24'd0 : PWRUP_CYC - 24'd1;
   localparam logic [23:0] GAP_LAST     = (GAP_CYC == 16'd0) ? 24'd0 : {8'd0, GAP_CYC} - 24'd1;
   localparam logic [23:0] TIMEOUT_LAST = (TIMEOUT_CYC == 24'd0) ? 24'd0 : TIMEOUT_CYC - 24'd1;
   localparam logic [7:0]  LAST_IDX     = (NUM_REGS == 8'd0) ? 8'd0 : NUM_REGS - 8'd1;
   localparam logic [2:0]  RETRY_LIM    = 3'(RETRY_MAX);

   typedef enum logic [3:0] {
      S_IDLE,
      S_PWRUP,
      S_FETCH,
      S_LOAD,
      S_SREQ,
      S_SWAIT,
      S_CHECK,
      S_GAP,
      S_NEXT,
      S_DONE,
      S_FAIL
   } state_t;

   state_t      state_q;
   logic        runPrev_q;
   logic [23:0] cnt_q;
   logic [2:0]  retry_q;
   logic [7:0]  idx_q;
   logic [7:0]  sub_q;
   logic [7:0]  wdata_q;
   logic        ack_q;
   logic        start_q;
   logic        busy_q;
   logic        done_q;
   logic        error_q;
   logic [7:0]  failIdx_q;

   logic [23:0] cnt_d;
   logic        runRise;

   // One shared cycle counter serves power-up, gap and timeout; it saturates.
   always_comb begin
      cnt_d   = (cnt_q == 24'hFF_FFFF) ? cnt_q : cnt_q + 24'd1;
      runRise = run_i & ~runPrev_q;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q   <= AUTO_START ? S_PWRUP : S_IDLE;
         runPrev_q <= 1'b0;
         cnt_q     <= 24'd0;
         retry_q   <= 3'd0;
         idx_q     <= 8'd0;
         sub_q     <= 8'd0;
         wdata_q   <= 8'd0;
         ack_q     <= 1'b0;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         failIdx_q <= 8'd0;
      end else begin
         runPrev_q <= run_i;
         unique case (state_q)
            S_IDLE: begin
               busy_q  <= 1'b0;
               start_q <= 1'b0;
               if (runRise) begin
                  state_q   <= S_PWRUP;
                  busy_q    <= 1'b1;
                  done_q    <= 1'b0;
                  error_q   <= 1'b0;
                  failIdx_q <= 8'd0;
                  retry_q   <= 3'd0;
                  cnt_q     <= 24'd0;
               end
            end

            // The master may still be finishing a transfer cut off by reset.
            S_PWRUP: begin
               busy_q <= 1'b1;
               if (cnt_q >= PWRUP_LAST && i2c_end_i) begin
                  state_q <= S_FETCH;
                  idx_q   <= 8'd0;
                  cnt_q   <= 24'd0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            S_FETCH: begin
               busy_q  <= 1'b1;
               state_q <= S_LOAD;
            end

            S_LOAD: begin
               busy_q  <= 1'b1;
               sub_q   <= tbl_data_i[15:8];
               wdata_q <= tbl_data_i[7:0];
               cnt_q   <= 24'd0;
               state_q <= S_SREQ;
            end

            // START is raised only while END=1 and held until the master drops END.
            S_SREQ: begin
               busy_q <= 1'b1;
               if (start_q && !i2c_end_i) begin
                  start_q <= 1'b0;
                  cnt_q   <= cnt_d;
                  state_q <= S_SWAIT;
               end else if (cnt_q >= TIMEOUT_LAST) begin
                  start_q <= 1'b0;
                  state_q <= S_FAIL;
               end else begin
                  start_q <= start_q | i2c_end_i;
                  cnt_q   <= cnt_d;
               end
            end

            S_SWAIT: begin
               busy_q <= 1'b1;
               if (i2c_end_i) begin
                  ack_q   <= i2c_ack_i;
                  state_q <= S_CHECK;
               end else if (cnt_q >= TIMEOUT_LAST) begin
                  state_q <= S_FAIL;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            S_CHECK: begin
               busy_q <= 1'b1;
               if (ack_q) begin
                  state_q <= S_NEXT;
               end else if (retry_q < RETRY_LIM) begin
                  retry_q <= retry_q + 3'd1;
                  cnt_q   <= 24'd0;
                  state_q <= S_GAP;
               end else begin
                  state_q <= S_FAIL;
               end
            end

            S_GAP: begin
               busy_q <= 1'b1;
               if (cnt_q >= GAP_LAST) begin
                  cnt_q   <= 24'd0;
                  state_q <= S_SREQ;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            S_NEXT: begin
               busy_q  <= 1'b1;
               retry_q <= 3'd0;
               if (idx_q == LAST_IDX) begin
                  state_q <= S_DONE;
               end else begin
                  idx_q   <= idx_q + 8'd1;
                  state_q <= S_FETCH;
               end
            end

            S_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end

            S_FAIL: begin
               error_q   <= 1'b1;
               failIdx_q <= idx_q;
               busy_q    <= 1'b0;
               start_q   <= 1'b0;
               state_q   <= S_IDLE;
            end

            default: begin
               busy_q  <= 1'b0;
               start_q <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign tbl_idx_o     = idx_q;
   assign i2c_start_o   = start_q;
   assign i2c_read_o    = 1'b0;
   assign i2c_addr_o    = DEV_ADDR;
   assign i2c_subaddr_o = sub_q;
   assign i2c_wdata_o   = wdata_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign error_o       = error_q;
   assign fail_idx_o    = failIdx_q;

endmodule

// File: tb/tb_i2c_init_seq.sv
// Self-checking bench for i2c_init_seq: behavioural i2c_master/slave plus a
// write-list reference model derived from the table and the slave's NACK plan.
module tb_i2c_init_seq;

   localparam int NREGS   = 4;
   localparam int PWRUP   = 20;
   localparam int RETRIES = 3;
   localparam int GAP     = 15;
   localparam int TMO     = 200;
   localparam logic [6:0] DEV = 7'h39;

   typedef struct {
      logic [6:0] addr;
      logic [7:0] sub;
      logic [7:0] data;
      int         stamp;
   } txn_t;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        run = 1'b0;
   logic [7:0]  tblIdx;
   logic [15:0] tblData = 16'd0;
   logic        i2cStart, i2cRead;
   logic [6:0]  i2cAddr;
   logic [7:0]  i2cSub, i2cWdata;
   logic        mEnd = 1'b1;
   logic        mAck = 1'b0;
   logic        busy, done, error;
   logic [7:0]  failIdx;

   logic [7:0]  tblSub [NREGS];
   logic [7:0]  tblDat [NREGS];
   int          nackPlan [NREGS];
   int          attempts [NREGS];
   txn_t        obs [$];
   txn_t        expQ [$];
   bit          expDone, expErr;
   logic [7:0]  expFail;

   int          busyLen = 5;
   bit          hang = 1'b0;
   int          hangEntry = 0;
   bit          hangTxn = 1'b0;
   bit          clearObs = 1'b0;
   int          mBusy = 0;
   logic        mAckPend = 1'b0;
   logic        startPrev = 1'b0;
   int          cyc = 0;
   int          protoErr = 0;
   int          idxErr = 0;
   int          compared = 0;
   int          mismatched = 0;

   always #5 clk = ~clk;

   i2c_init_seq #(
      .DEV_ADDR   (DEV),
      .NUM_REGS   (8'(NREGS)),
      .PWRUP_CYC  (24'(PWRUP)),
      .RETRY_MAX  (RETRIES),
      .GAP_CYC    (16'(GAP)),
      .TIMEOUT_CYC(24'(TMO)),
      .AUTO_START (1'b1)
   ) dut (
      .clk_i        (clk),
      .reset_n_i    (resetN),
      .run_i        (run),
      .tbl_idx_o    (tblIdx),
      .tbl_data_i   (tblData),
      .i2c_start_o  (i2cStart),
      .i2c_read_o   (i2cRead),
      .i2c_addr_o   (i2cAddr),
      .i2c_subaddr_o(i2cSub),
      .i2c_wdata_o  (i2cWdata),
      .i2c_end_i    (mEnd),
      .i2c_ack_i    (mAck),
      .busy_o       (busy),
      .done_o       (done),
      .error_o      (error),
      .fail_idx_o   (failIdx)
   );

   // Registered table ROM plus a master/slave model; sub-address bits [7:6] name the entry.
   always @(posedge clk) begin
      cyc       <= cyc + 1;
      startPrev <= i2cStart;
      tblData   <= {tblSub[tblIdx[1:0]], tblDat[tblIdx[1:0]]};
      if (tblIdx > 8'(NREGS - 1)) idxErr <= idxErr + 1;
      if (clearObs) begin
         obs.delete();
         for (int k = 0; k < NREGS; k++) attempts[k] <= 0;
      end
      if (mBusy == 0) begin
         mEnd <= 1'b1;
         if (i2cStart && !startPrev) begin
            obs.push_back('{i2cAddr, i2cSub, i2cWdata, cyc});
            mAckPend <= (attempts[i2cSub[7:6]] >= nackPlan[i2cSub[7:6]]);
            attempts[i2cSub[7:6]] <= attempts[i2cSub[7:6]] + 1;
            hangTxn <= hang && (int'(i2cSub[7:6]) == hangEntry);
            mBusy <= busyLen;
            mEnd  <= 1'b0;
         end
      end else begin
         if (i2cStart && !startPrev) protoErr <= protoErr + 1;
         if (!(hang && hangTxn)) begin
            mBusy <= mBusy - 1;
            if (mBusy == 1) begin
               mEnd <= 1'b1;
               mAck <= mAckPend;
            end
         end
      end
   end

   // Reference: each entry is sent min(nacks, RETRIES)+1 times; beyond RETRIES the run stops there.
   function automatic void build_expect();
      int tries;
      expQ.delete();
      expDone = 1'b1;
      expErr  = 1'b0;
      expFail = 8'd0;
      for (int i = 0; i < NREGS; i++) begin
         tries = (nackPlan[i] > RETRIES) ? RETRIES + 1 : nackPlan[i] + 1;
         for (int a = 0; a < tries; a++) expQ.push_back('{DEV, tblSub[i], tblDat[i], 0});
         if (nackPlan[i] > RETRIES) begin
            expDone = 1'b0;
            expErr  = 1'b1;
            expFail = 8'(i);
            break;
         end
      end
   endfunction

   function automatic int first_diff();
      int n;
      n = (obs.size() < expQ.size()) ? obs.size() : expQ.size();
      for (int i = 0; i < n; i++)
         if (obs[i].addr !== expQ[i].addr || obs[i].sub !== expQ[i].sub || obs[i].data !== expQ[i].data)
            return i;
      if (obs.size() != expQ.size()) return n;
      return -1;
   endfunction

   task automatic randomize_table();
      for (int i = 0; i < NREGS; i++) begin
         tblSub[i] = {2'(i), 6'($urandom)};
         tblDat[i] = 8'($urandom);
      end
   endtask

   task automatic clear_obs();
      @(negedge clk) clearObs = 1'b1;
      @(negedge clk) clearObs = 1'b0;
   endtask

   task automatic pulse_run();
      @(negedge clk) run = 1'b1;
      repeat (2) @(negedge clk);
      run = 1'b0;
   endtask

   task automatic wait_idle(input int bound, output bit ok);
      int n = 0;
      while (busy !== 1'b0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      ok = (busy === 1'b0);
   endtask

   task automatic wait_busy_cycle(input int bound, output bit ok);
      int n = 0;
      while (busy !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b1) ok = 1'b0;
      else wait_idle(bound, ok);
   endtask

   task automatic test_reset();
      randomize_table();
      for (int i = 0; i < NREGS; i++) nackPlan[i] = 0;
      resetN = 1'b0;
      repeat (3) @(negedge clk);
      compared++;
      if ({busy, done, error, i2cStart, i2cRead} !== 5'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_flags: got %b want 00000", {busy, done, error, i2cStart, i2cRead});
      end
      compared++;
      if ({i2cAddr, i2cSub, i2cWdata, tblIdx, failIdx} !== {DEV, 32'd0}) begin
         mismatched++;
         $display("[TB] FAIL reset_values: got %h want %h", {i2cAddr, i2cSub, i2cWdata, tblIdx, failIdx}, {DEV, 32'd0});
      end
   endtask

   task automatic test_autostart();
      bit ok;
      int d;
      build_expect();
      @(negedge clk) resetN = 1'b1;
      wait_busy_cycle(3000, ok);
      compared++;
      if (!ok) begin mismatched++; $display("[TB] FAIL autostart_busy: got busy=%b want 0 within bound", busy); end
      d = first_diff();
      compared++;
      if (d != -1) begin mismatched++; $display("[TB] FAIL autostart_seq: first diff at %0d, got %0d writes want %0d", d, obs.size(), expQ.size()); end
      compared++;
      if ({done, error} !== 2'b10) begin mismatched++; $display("[TB] FAIL autostart_status: got done,error=%b want 10", {done, error}); end
   endtask

   task automatic test_retry();
      bit ok;
      int d, dt;
      randomize_table();
      for (int i = 0; i < NREGS; i++) nackPlan[i] = $urandom_range(0, RETRIES);
      nackPlan[1] = 2;
      busyLen = $urandom_range(3, 8);
      build_expect();
      clear_obs();
      pulse_run();
      wait_idle(5000, ok);
      compared++;
      if (!ok) begin mismatched++; $display("[TB] FAIL retry_idle: got busy=%b want 0 within bound", busy); end
      d = first_diff();
      compared++;
      if (d != -1) begin mismatched++; $display("[TB] FAIL retry_seq: first diff at %0d, got %0d writes want %0d", d, obs.size(), expQ.size()); end
      compared++;
      if ({done, error} !== 2'b10) begin mismatched++; $display("[TB] FAIL retry_status: got done,error=%b want 10", {done, error}); end
      for (int i = 1; i < obs.size(); i++) begin
         if (obs[i].sub == obs[i-1].sub) begin
            dt = obs[i].stamp - obs[i-1].stamp;
            compared++;
            if (dt < GAP + busyLen || dt > GAP + busyLen + 8) begin
               mismatched++;
               $display("[TB] FAIL retry_gap: got %0d cycles between attempts want %0d..%0d", dt, GAP + busyLen, GAP + busyLen + 8);
            end
         end
      end
   endtask

   task automatic test_fail();
      bit ok;
      int d, f;
      randomize_table();
      f = $urandom_range(0, NREGS - 1);
      for (int i = 0; i < NREGS; i++) nackPlan[i] = $urandom_range(0, 1);
      nackPlan[f] = 99;
      busyLen = 4;
      build_expect();
      clear_obs();
      pulse_run();
      wait_idle(5000, ok);
      d = first_diff();
      compared++;
      if (!ok || d != -1) begin mismatched++; $display("[TB] FAIL fail_seq: first diff at %0d, got %0d writes want %0d", d, obs.size(), expQ.size()); end
      compared++;
      if ({done, error, failIdx} !== {2'b01, 8'(f)}) begin
         mismatched++;
         $display("[TB] FAIL fail_status: got done,error,idx=%b,%b,%0d want 0,1,%0d", done, error, failIdx, f);
      end
   endtask

   task automatic test_random_plans();
      bit ok;
      int d;
      for (int it = 0; it < 4; it++) begin
         randomize_table();
         for (int i = 0; i < NREGS; i++) nackPlan[i] = $urandom_range(0, RETRIES + 2);
         busyLen = $urandom_range(3, 8);
         build_expect();
         clear_obs();
         pulse_run();
         wait_idle(6000, ok);
         d = first_diff();
         compared++;
         if (!ok || d != -1) begin mismatched++; $display("[TB] FAIL random_seq%0d: first diff at %0d, got %0d writes want %0d", it, d, obs.size(), expQ.size()); end
         compared++;
         if ({done, error} !== {expDone, expErr} || (expErr && failIdx !== expFail)) begin
            mismatched++;
            $display("[TB] FAIL random_status%0d: got done,error,idx=%b,%b,%0d want %b,%b,%0d", it, done, error, failIdx, expDone, expErr, expFail);
         end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int dt, n;
      randomize_table();
      for (int i = 0; i < NREGS; i++) nackPlan[i] = 0;
      busyLen = 5;
      hangEntry = $urandom_range(0, NREGS - 1);
      hang = 1'b1;
      clear_obs();
      pulse_run();
      wait_idle(3000, ok);
      dt = (obs.size() > 0) ? cyc - obs[obs.size()-1].stamp : -1;
      compared++;
      if (!ok || {done, error, failIdx} !== {2'b01, 8'(hangEntry)}) begin
         mismatched++;
         $display("[TB] FAIL timeout_status: got done,error,idx=%b,%b,%0d want 0,1,%0d", done, error, failIdx, hangEntry);
      end
      compared++;
      if (dt < TMO - 4 || dt > TMO + 4) begin mismatched++; $display("[TB] FAIL timeout_delay: got %0d cycles after START want %0d..%0d", dt, TMO - 4, TMO + 4); end
      compared++;
      if (obs.size() != hangEntry + 1) begin mismatched++; $display("[TB] FAIL timeout_writes: got %0d want %0d", obs.size(), hangEntry + 1); end
      hang = 1'b0;
      n = 0;
      while (mEnd !== 1'b1 && n < 100) begin @(negedge clk); n++; end
   endtask

   task automatic test_busy_ignored();
      bit ok;
      int d, n;
      randomize_table();
      for (int i = 0; i < NREGS; i++) nackPlan[i] = 0;
      busyLen = 6;
      build_expect();
      clear_obs();
      pulse_run();
      n = 0;
      while (obs.size() < 2 && n < 500) begin @(negedge clk); n++; end
      pulse_run();
      wait_idle(3000, ok);
      d = first_diff();
      compared++;
      if (!ok || d != -1) begin mismatched++; $display("[TB] FAIL busy_run_seq: first diff at %0d, got %0d writes want %0d", d, obs.size(), expQ.size()); end
      compared++;
      if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL busy_run_done: got %b want 1", done); end
   endtask

   task automatic test_run_held();
      bit ok;
      int d, busyCnt;
      randomize_table();
      for (int i = 0; i < NREGS; i++) nackPlan[i] = 0;
      build_expect();
      clear_obs();
      @(negedge clk) run = 1'b1;
      wait_busy_cycle(3000, ok);
      busyCnt = 0;
      repeat (60) begin
         @(negedge clk);
         if (busy === 1'b1) busyCnt++;
      end
      run = 1'b0;
      d = first_diff();
      compared++;
      if (!ok || d != -1) begin mismatched++; $display("[TB] FAIL held_run_seq: first diff at %0d, got %0d writes want %0d", d, obs.size(), expQ.size()); end
      compared++;
      if (busyCnt != 0) begin mismatched++; $display("[TB] FAIL held_run_retrigger: got %0d busy cycles want 0", busyCnt); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int d, n, relCyc, endBackCyc;
      randomize_table();
      for (int i = 0; i < NREGS; i++) nackPlan[i] = 0;
      busyLen = 30;
      build_expect();
      clear_obs();
      pulse_run();
      n = 0;
      while (obs.size() < 2 && n < 500) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      resetN = 1'b0;
      @(negedge clk);
      compared++;
      if ({i2cStart, busy, done, tblIdx, i2cSub, i2cWdata} !== 27'd0) begin
         mismatched++;
         $display("[TB] FAIL midreset_outputs: got %h want 0", {i2cStart, busy, done, tblIdx, i2cSub, i2cWdata});
      end
      resetN = 1'b1;
      relCyc = cyc;
      clear_obs();
      n = 0;
      while (mEnd !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      endBackCyc = cyc;
      busyLen = 5;
      wait_idle(4000, ok);
      d = first_diff();
      compared++;
      if (!ok || d != -1) begin mismatched++; $display("[TB] FAIL midreset_seq: first diff at %0d, got %0d writes want %0d", d, obs.size(), expQ.size()); end
      compared++;
      if (obs.size() == 0 || obs[0].stamp < relCyc + PWRUP || obs[0].stamp < endBackCyc - 1) begin
         mismatched++;
         $display("[TB] FAIL midreset_restart: got first START at %0d want >= %0d and >= %0d", (obs.size() > 0) ? obs[0].stamp : -1, relCyc + PWRUP, endBackCyc - 1);
      end
   endtask

   task automatic test_invariants();
      compared++;
      if (protoErr != 0) begin mismatched++; $display("[TB] FAIL start_while_busy: got %0d want 0", protoErr); end
      compared++;
      if (idxErr != 0) begin mismatched++; $display("[TB] FAIL tbl_idx_range: got %0d out-of-range cycles want 0", idxErr); end
   endtask

   initial begin
      test_reset();
      test_autostart();
      test_retry();
      test_fail();
      test_random_plans();
      test_timeout();
      test_busy_ignored();
      test_run_held();
      test_reset_mid();
      test_invariants();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got no completion want completion before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
